// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle RV32I control FSM (PC select, opcodes, alu_op, wb_sel, op class)
package mc_ctrl_pkg;
  localparam logic [1:0] PC_STEP = 2'b00;
  localparam logic [1:0] PC_JP_R = 2'b01;
  localparam logic [1:0] PC_JP_F = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_FUNCT  = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [2:0] F3_BEQ = 3'b000;
  typedef struct packed {
    logic r;
    logic i;
    logic lui;
    logic lw;
    logic sw;
    logic br;
    logic jal;
    logic jalr;
  } op_class_t;
  function automatic logic is_known(input op_class_t c);
    return |c;
  endfunction
endpackage

// File: rtl/mc_ctrl_opclass.sv
// mc_ctrl_opclass: maps an opcode to a one-hot instruction class (all zero for unknown opcodes)
module mc_ctrl_opclass
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);
  always_comb begin
    cls.r    = opcode == OP_R;
    cls.i    = opcode == OP_I;
    cls.lui  = opcode == OP_LUI;
    cls.lw   = opcode == OP_LW;
    cls.sw   = opcode == OP_SW;
    cls.br   = opcode == OP_BR;
    cls.jal  = opcode == OP_JAL;
    cls.jalr = opcode == OP_JALR;
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB control sequencer for the multi-cycle RV32I CPU.
// CTRL_ILLEGAL_HALT_EN: unknown opcodes park the machine in HALT instead of retiring as a NOP.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_update_sel,
  output logic       ir_write,
  output logic       rs_write,
  output logic       alu_b_sel,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       halted
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef CTRL_ILLEGAL_HALT_EN
  localparam logic [2:0] S_HALT   = 3'd5;
`endif
  logic [2:0] state, state_nx;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic [6:0] dec_op;
  op_class_t  cls;
  logic       taken, pc_we;
  logic [1:0] pc_sel;
  // DECODE classifies the live IR opcode; later states use the latched copy
  assign dec_op = (state == S_DECODE) ? opcode : op_q;
  mc_ctrl_opclass u_opclass (.opcode(dec_op), .cls(cls));
  assign taken = (f3_q == F3_BEQ) ? alu_zero : ~alu_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= '0;
      f3_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
    end
  end
  always_comb begin
    state_nx  = state;
    pc_we     = 1'b0;
    pc_sel    = PC_STEP;
    ir_write  = 1'b0;
    rs_write  = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        rs_write = 1'b1;
        if (is_known(cls)) state_nx = S_EXEC;
`ifdef CTRL_ILLEGAL_HALT_EN
        else state_nx = S_HALT;
`else
        else begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
`endif
      end
      S_EXEC: begin
        if (cls.r | cls.i | cls.lui) begin
          alu_op    = cls.lui ? ALU_PASS_B : ALU_FUNCT;
          alu_b_sel = ~cls.r;
          state_nx  = S_WB;
        end else if (cls.lw | cls.sw) begin
          alu_b_sel = 1'b1;
          state_nx  = S_MEM;
        end else if (cls.br) begin
          alu_op   = ALU_SUB;
          pc_we    = taken;
          pc_sel   = PC_JP_R;
          retire   = 1'b1;
          state_nx = S_FETCH;
        end else begin
          alu_b_sel = cls.jalr;
          pc_we     = 1'b1;
          pc_sel    = cls.jalr ? PC_JP_F : PC_JP_R;
          reg_write = 1'b1;
          wb_sel    = WB_LINK;
          retire    = 1'b1;
          state_nx  = S_FETCH;
        end
      end
      S_MEM: begin
        alu_b_sel = 1'b1;
        mem_read  = cls.lw;
        mem_write = cls.sw;
        if (mem_ready) begin
          retire   = cls.sw;
          state_nx = cls.lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = cls.lw ? WB_MEM : WB_ALU;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_HALT_EN
      S_HALT: state_nx = S_HALT;
`endif
      default: state_nx = S_FETCH;
    endcase
    if (rst) begin
      pc_we     = 1'b0;
      ir_write  = 1'b0;
      rs_write  = 1'b0;
      alu_b_sel = 1'b0;
      alu_op    = ALU_ADD;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      retire    = 1'b0;
    end
  end
  assign pc_write      = pc_we;
  assign pc_update_sel = pc_we ? pc_sel : PC_HOLD;
`ifdef CTRL_ILLEGAL_HALT_EN
  assign halted = (state == S_HALT) & ~rst;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write, ir_write, rs_write, alu_b_sel, mem_read, mem_write, reg_write, retire, halted;
  logic [1:0] pc_update_sel, alu_op, wb_sel;
  logic [14:0] obs, exp_v;
  int checks = 0;
  int errors = 0;
  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_update_sel(pc_update_sel),
    .ir_write(ir_write), .rs_write(rs_write), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
    .retire(retire), .halted(halted)
  );
  always #5 clk = ~clk;
  assign obs = {pc_write, pc_update_sel, ir_write, rs_write, alu_b_sel, alu_op,
                mem_read, mem_write, reg_write, wb_sel, retire, halted};
  function automatic logic [14:0] ev(input logic pw, input logic [1:0] sel, input logic ir, rs, bs,
                                     input logic [1:0] aop, input logic mr, mw, rw,
                                     input logic [1:0] wb, input logic ret, h);
    return {pw, sel, ir, rs, bs, aop, mr, mw, rw, wb, ret, h};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
    mem_ready = 1'b1;
    opcode = op;
    funct3 = f3;
    tick();
    tick();
  endtask
  task automatic test_reset;
    rst = 1'b1; mem_ready = 1'b1; opcode = 7'b0010011; funct3 = 3'b000; alu_zero = 1'b0;
    tick();
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL reset_hold got %b exp %b", obs, exp_v); end
    checks++;
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL reset_fetch got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    if (obs !== exp_v) begin errors++; $display("FAIL fetch_stall got %b exp %b", obs, exp_v); end
    checks++;
  endtask
  task automatic test_addi;
    mem_ready = 1'b1; opcode = 7'b0010011; funct3 = 3'b000;
    #1;
    exp_v = ev(1, 2'b00, 1, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL addi_fetch got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    exp_v = ev(0, 2'b11, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL addi_decode got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 1, 2'b01, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL addi_exec got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL addi_wb got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    mem_ready = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL addi_next_fetch got %b exp %b", obs, exp_v); end
    checks++;
  endtask
  task automatic test_alu_classes;
    fetch_decode(7'b0110011, 3'b000);
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL r_exec got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    tick();
    fetch_decode(7'b0110111, 3'b000);
    exp_v = ev(0, 2'b11, 0, 0, 1, 2'b11, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL lui_exec got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL lui_wb got %b exp %b", obs, exp_v); end
    checks++;
    tick();
  endtask
  task automatic test_lw_stall;
    fetch_decode(7'b0000011, 3'b010);
    mem_ready = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL lw_exec got %b exp %b", obs, exp_v); end
    checks++;
    exp_v = ev(0, 2'b11, 0, 0, 1, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_ready = (k == 2);
      #1;
      if (obs !== exp_v) begin errors++; $display("FAIL lw_mem%0d got %b exp %b", k, obs, exp_v); end
      checks++;
    end
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 1, 2'b01, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL lw_wb got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    mem_ready = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL lw_next_fetch got %b exp %b", obs, exp_v); end
    checks++;
  endtask
  task automatic test_branch;
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b100};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       tks [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      fetch_decode(7'b1100011, f3s[k]);
      alu_zero = zs[k];
      #1;
      exp_v = tks[k] ? ev(1, 2'b01, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00, 1, 0)
                     : ev(0, 2'b11, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00, 1, 0);
      if (obs !== exp_v) begin errors++; $display("FAIL branch%0d_exec got %b exp %b", k, obs, exp_v); end
      checks++;
      tick();
      mem_ready = 1'b0; alu_zero = 1'b0;
      #1;
      exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
      if (obs !== exp_v) begin errors++; $display("FAIL branch%0d_fetch got %b exp %b", k, obs, exp_v); end
      checks++;
    end
  endtask
  task automatic test_jumps;
    fetch_decode(7'b1101111, 3'b000);
    exp_v = ev(1, 2'b01, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL jal_exec got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    fetch_decode(7'b1100111, 3'b000);
    exp_v = ev(1, 2'b10, 0, 0, 1, 2'b00, 0, 0, 1, 2'b10, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL jalr_exec got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    mem_ready = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL jalr_next_fetch got %b exp %b", obs, exp_v); end
    checks++;
  endtask
  task automatic test_sw_reset;
    fetch_decode(7'b0100011, 3'b010);
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 1, 2'b00, 0, 1, 0, 2'b00, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL sw_mem_done got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    fetch_decode(7'b0100011, 3'b010);
    mem_ready = 1'b0;
    tick();
    exp_v = ev(0, 2'b11, 0, 0, 1, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL sw_mem_stall got %b exp %b", obs, exp_v); end
    checks++;
    rst = 1'b1;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL sw_rst_mid_mem got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    rst = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL sw_rst_fetch got %b exp %b", obs, exp_v); end
    checks++;
  endtask
  task automatic test_illegal;
    mem_ready = 1'b1; opcode = 7'b0000000;
    tick();
`ifdef CTRL_ILLEGAL_HALT_EN
    exp_v = ev(0, 2'b11, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL illegal_decode got %b exp %b", obs, exp_v); end
    checks++;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (obs !== exp_v) begin errors++; $display("FAIL halt%0d got %b exp %b", k, obs, exp_v); end
      checks++;
    end
    rst = 1'b1;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL halt_rst got %b exp %b", obs, exp_v); end
    checks++;
    tick();
    rst = 1'b0;
`else
    exp_v = ev(0, 2'b11, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL illegal_nop_decode got %b exp %b", obs, exp_v); end
    checks++;
    tick();
`endif
    mem_ready = 1'b0;
    #1;
    exp_v = ev(0, 2'b11, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    if (obs !== exp_v) begin errors++; $display("FAIL illegal_fetch got %b exp %b", obs, exp_v); end
    checks++;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_addi();
    test_alu_classes();
    test_lw_stall();
    test_branch();
    test_jumps();
    test_sw_reset();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
